// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg_if
//  Purpose  : Handshake bundle between two adjacent pipeline stages, carrying
//             the flush strobe, the upstream offer (valid/ctrl/data/err) with
//             its ready, and the downstream offer with its ready.
//  Modports : master - the environment around a stage (drives in_*, flush,
//                      out_ready; observes in_ready and out_*)
//             slave  - the stage register itself
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_stage_reg_if #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 64
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              in_err;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic              out_err;

   modport master (
      output flush, in_valid, in_ctrl, in_data, in_err, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data, out_err
   );

   modport slave (
      input  flush, in_valid, in_ctrl, in_data, in_err, out_ready,
      output in_ready, out_valid, out_ctrl, out_data, out_err
   );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Parametrised pipeline stage register with valid/ready stall,
//             synchronous flush (bubble insertion) and an optional one-entry
//             skid buffer that lets in_ready come straight from a flop.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - pipe_stage_reg_if.slave: flush, in_valid/in_ready/
//                    in_ctrl/in_data/in_err (upstream side) and
//                    out_valid/out_ready/out_ctrl/out_data/out_err
//                    (downstream side)
//  Params   : CTRL_W, DATA_W - control word / payload widths (must match bus)
//             CTRL_BUBBLE    - control word shown while no entry is valid
//             SKID           - 1: main + skid entry, registered in_ready
//                              0: single entry, combinational in_ready
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
   parameter int                CTRL_W      = 16,
   parameter int                DATA_W      = 64,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
   parameter int                SKID        = 1
) (
   input wire logic           clk,
   input wire logic           rst,
   pipe_stage_reg_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;

   logic [CTRL_W-1:0] r_mainCtrl;
   logic [DATA_W-1:0] r_mainData;
   logic              r_mainErr;

   logic [CTRL_W-1:0] w_skidCtrl;
   logic [DATA_W-1:0] w_skidData;
   logic              w_skidErr;

   logic              w_mainValid;
   logic              w_inReady;
   logic              w_inXfer;
   logic              w_outXfer;
   logic              w_loadMainIn;
   logic              w_loadMainSkid;
   logic              w_loadSkid;

   assign w_mainValid = (r_state != ST_EMPTY);
   // Flush kills the same-cycle input even when the handshake completes.
   assign w_inXfer    = bus.in_valid & w_inReady & ~bus.flush;
   assign w_outXfer   = w_mainValid & bus.out_ready;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and entry-load strobes
   // ------------------------------------------------------------------------
   always_comb begin
      w_stateNext    = r_state;
      w_loadMainIn   = 1'b0;
      w_loadMainSkid = 1'b0;
      w_loadSkid     = 1'b0;

      if (bus.flush) begin
         w_stateNext = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_inXfer) begin
                  w_loadMainIn = 1'b1;
                  w_stateNext  = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_inXfer && w_outXfer) begin
                  w_loadMainIn = 1'b1;
               end else if (w_inXfer && (SKID != 0)) begin
                  // Downstream stalled this cycle: park the new entry in S.
                  w_loadSkid  = 1'b1;
                  w_stateNext = ST_TWO;
               end else if (w_outXfer) begin
                  w_stateNext = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_outXfer) begin
                  w_loadMainSkid = 1'b1;
                  w_stateNext    = ST_ONE;
               end
            end
            default: begin
               w_stateNext = ST_EMPTY;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Main entry
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mainCtrl <= '0;
         r_mainData <= '0;
         r_mainErr  <= 1'b0;
      end else if (w_loadMainIn) begin
         r_mainCtrl <= bus.in_ctrl;
         r_mainData <= bus.in_data;
         r_mainErr  <= bus.in_err;
      end else if (w_loadMainSkid) begin
         r_mainCtrl <= w_skidCtrl;
         r_mainData <= w_skidData;
         r_mainErr  <= w_skidErr;
      end
   end

   // ------------------------------------------------------------------------
   // Skid entry and in_ready generation
   // ------------------------------------------------------------------------
   generate
      if (SKID != 0) begin : g_skid
         logic [CTRL_W-1:0] r_skidCtrl;
         logic [DATA_W-1:0] r_skidData;
         logic              r_skidErr;
         logic              r_inReady;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_skidCtrl <= '0;
               r_skidData <= '0;
               r_skidErr  <= 1'b0;
            end else if (w_loadSkid) begin
               r_skidCtrl <= bus.in_ctrl;
               r_skidData <= bus.in_data;
               r_skidErr  <= bus.in_err;
            end
         end

         // Registered copy of ~sv: computed from the next state so it is
         // exact every cycle, yet out_ready never reaches in_ready
         // combinationally.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_inReady <= 1'b1;
            end else begin
               r_inReady <= (w_stateNext != ST_TWO);
            end
         end

         assign w_skidCtrl = r_skidCtrl;
         assign w_skidData = r_skidData;
         assign w_skidErr  = r_skidErr;
         assign w_inReady  = r_inReady;
      end else begin : g_noSkid
         assign w_skidCtrl = '0;
         assign w_skidData = '0;
         assign w_skidErr  = 1'b0;
         // Single entry: accept when empty or when the held entry leaves now.
         assign w_inReady  = ~w_mainValid | bus.out_ready;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = w_mainValid;
   assign bus.out_ctrl  = w_mainValid ? r_mainCtrl : CTRL_BUBBLE;
   assign bus.out_data  = r_mainData;
   assign bus.out_err   = r_mainErr & w_mainValid;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg. Drives one SKID=1 and
//             one SKID=0 instance with the same stimulus; each has a
//             capacity-limited FIFO reference model that predicts in_ready,
//             the presented entry and the last-loaded payload.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam int             CW   = 16;
   localparam int             DW   = 64;
   localparam logic [CW-1:0]  BUB1 = 16'hB0B1;
   localparam logic [CW-1:0]  BUB0 = 16'h0000;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic          e;
   } ent_t;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          flush    = 1'b0;
   logic          inValid  = 1'b0;
   logic [CW-1:0] inCtrl   = '0;
   logic [DW-1:0] inData   = '0;
   logic          inErr    = 1'b0;
   logic          outReady = 1'b0;

   int nChecks = 0;
   int nPass   = 0;

   // Reference model: ordered held entries, front = entry on the outputs.
   ent_t          mq    [2][2];
   int            mcnt  [2];
   logic [DW-1:0] lastD [2];

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus1 ();
   pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus0 ();

   assign bus1.flush = flush;    assign bus0.flush = flush;
   assign bus1.in_valid = inValid; assign bus0.in_valid = inValid;
   assign bus1.in_ctrl = inCtrl;  assign bus0.in_ctrl = inCtrl;
   assign bus1.in_data = inData;  assign bus0.in_data = inData;
   assign bus1.in_err = inErr;    assign bus0.in_err = inErr;
   assign bus1.out_ready = outReady; assign bus0.out_ready = outReady;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUB1), .SKID(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUB0), .SKID(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("FAIL %s skid=%0d t=%0t actual=%h expected=%h", name, k, $time, act, exp);
      end
   endtask

   task automatic rstChk(input int k, input logic vld, input logic rdy,
                         input logic [CW-1:0] oc, input logic [DW-1:0] od,
                         input logic oe, input logic [CW-1:0] bub);
      chk("rst_out_valid", k, 64'(vld), 64'd0);
      chk("rst_in_ready",  k, 64'(rdy), 64'd1);
      chk("rst_out_ctrl",  k, 64'(oc),  64'(bub));
      chk("rst_out_data",  k, od,       64'd0);
      chk("rst_out_err",   k, 64'(oe),  64'd0);
   endtask

   // Compare one DUT against its model, then advance the model by the
   // transfers that happen at the coming rising edge.
   task automatic mon(input int k, input logic vld, input logic rdy,
                      input logic [CW-1:0] oc, input logic [DW-1:0] od,
                      input logic oe, input logic [CW-1:0] bub);
      logic expRdy;
      logic inX;
      logic outX;
      ent_t cur;
      expRdy = (k == 1) ? (mcnt[k] < 2) : ((mcnt[k] == 0) || outReady);
      chk("in_ready",  k, 64'(rdy), 64'(expRdy));
      chk("out_valid", k, 64'(vld), 64'(mcnt[k] != 0));
      if (mcnt[k] != 0) begin
         chk("out_ctrl", k, 64'(oc), 64'(mq[k][0].c));
         chk("out_err",  k, 64'(oe), 64'(mq[k][0].e));
      end else begin
         chk("bubble_ctrl", k, 64'(oc), 64'(bub));
         chk("idle_err",    k, 64'(oe), 64'd0);
      end
      chk("out_data", k, od, lastD[k]);

      outX = (mcnt[k] != 0) && outReady;
      inX  = inValid && expRdy && !flush;
      cur  = '{c: inCtrl, d: inData, e: inErr};
      if (outX) begin
         mq[k][0] = mq[k][1];
         mcnt[k]  = mcnt[k] - 1;
      end
      if (flush) begin
         mcnt[k] = 0;
      end else if (inX) begin
         mq[k][mcnt[k]] = cur;
         mcnt[k]        = mcnt[k] + 1;
      end
      if (mcnt[k] != 0) lastD[k] = mq[k][0].d;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         rstChk(1, bus1.out_valid, bus1.in_ready, bus1.out_ctrl, bus1.out_data, bus1.out_err, BUB1);
         rstChk(0, bus0.out_valid, bus0.in_ready, bus0.out_ctrl, bus0.out_data, bus0.out_err, BUB0);
         for (int k = 0; k < 2; k++) begin
            mcnt[k]  = 0;
            lastD[k] = '0;
         end
      end else begin
         mon(1, bus1.out_valid, bus1.in_ready, bus1.out_ctrl, bus1.out_data, bus1.out_err, BUB1);
         mon(0, bus0.out_valid, bus0.in_ready, bus0.out_ctrl, bus0.out_data, bus0.out_err, BUB0);
      end
   end

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic e,
                        input logic r, input logic f);
      @(posedge clk);
      #1;
      inValid  = v;
      inData   = d;
      inCtrl   = d[CW-1:0] ^ d[DW-1:DW-CW] ^ 16'h5A5A;
      inErr    = e;
      outReady = r;
      flush    = f;
   endtask

   initial begin
      mcnt[0] = 0; mcnt[1] = 0;
      lastD[0] = '0; lastD[1] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Streaming with downstream always ready
      for (int i = 1; i <= 8; i++) drive(1'b1, 64'(i), 1'b0, 1'b1, 1'b0);
      repeat (2) drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

      // Stall with skid: A accepted, B lands in S, C held off
      drive(1'b1, 64'hA, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("stall_out_data", 1, bus1.out_data, 64'hA);
      chk("stall_in_ready", 1, 64'(bus1.in_ready), 64'd0);
      chk("stall_out_data", 0, bus0.out_data, 64'hA);
      chk("stall_in_ready", 0, 64'(bus0.in_ready), 64'd0);
      drive(1'b1, 64'hC, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 64'hC, 1'b0, 1'b1, 1'b0);
      repeat (3) drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

      // Flush from TWO together with a same-cycle offer
      drive(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 64'h33, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); #1;
      chk("flush_out_valid", 1, 64'(bus1.out_valid), 64'd0);
      chk("flush_out_ctrl",  1, 64'(bus1.out_ctrl), 64'(BUB1));
      chk("flush_in_ready",  1, 64'(bus1.in_ready), 64'd1);
      drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

      // Flush with offer while empty
      drive(1'b1, 64'h44, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

      // Error flag gating over a held entry
      drive(1'b1, 64'h55, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
      repeat (2) drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

      // Async reset while in TWO
      drive(1'b1, 64'h66, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      inValid = 1'b0;
      outReady = 1'b1;
      #1;
      rstChk(1, bus1.out_valid, bus1.in_ready, bus1.out_ctrl, bus1.out_data, bus1.out_err, BUB1);
      rstChk(0, bus0.out_valid, bus0.in_ready, bus0.out_ctrl, bus0.out_data, bus0.out_err, BUB0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) drive(1'b1, 64'h100 + 64'(i), 1'b0, 1'b1, 1'b0);

      // Randomised phases with varying stall pressure
      for (int i = 0; i < 1500; i++) begin
         int pr;
         pr = (i / 250) % 3;
         drive($urandom_range(0, 3) != 0,
               {$urandom, $urandom},
               1'($urandom_range(0, 1)),
               (pr == 0) ? 1'b1 : ($urandom_range(0, pr) == 0),
               $urandom_range(0, 40) == 0);
      end
      repeat (4) drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); #1;

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
